// File: rtl/alarm_pkg.sv
// Shared types and BCD limits for the alarm stage.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_e;

    localparam logic [3:0] BCD_ONES_MAX = 4'd9;
    localparam logic [3:0] MIN_TENS_MAX = 4'd5;
    localparam logic [3:0] HR_TENS_MAX  = 4'd2;
    localparam logic [7:0] HOUR_MAX     = 8'd23;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Tick-driven up-counter held at zero by clear; tc flags the tick that lands on TERM.
module tick_timer #(
    parameter int unsigned W    = 8,
    parameter int unsigned TERM = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic tc
);

    logic [W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = tick && (count_q == W'(TERM));

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm register file, time comparator and ring/snooze FSM driving the buzzer.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned TONE_DIV   = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Tick,
    input  logic [3:0] sec_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] min_tens,
    input  logic [3:0] hr_ones,
    input  logic [3:0] hr_tens,
    input  logic       alarm_on,
    input  logic       set_we,
    input  logic       set_sel,
    input  logic [3:0] set0,
    input  logic [3:0] set1,
    input  logic       stop,
    input  logic       snooze,
    output logic [3:0] al_min_ones,
    output logic [3:0] al_min_tens,
    output logic [3:0] al_hr_ones,
    output logic [3:0] al_hr_tens,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing
);

    localparam int unsigned TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    state_e        state_d, state_q;
    logic [3:0]    al_mo_d, al_mo_q, al_mt_d, al_mt_q;
    logic [3:0]    al_ho_d, al_ho_q, al_ht_d, al_ht_q;
    logic [TW-1:0] tone_cnt_d, tone_cnt_q;
    logic          buzzer_d, buzzer_q;
    logic          ringing_d, ringing_q;
    logic          snoozing_d, snoozing_q;
    logic          match, ring_tc, snz_tc;
    logic [3:0]    hr_t_clamped, hr_o_clamped;

    assign match = alarm_on && Tick
                && (hr_tens == al_ht_q) && (hr_ones == al_ho_q)
                && (min_tens == al_mt_q) && (min_ones == al_mo_q)
                && (sec_tens == 4'd0) && (sec_ones == 4'd0);

    // Both timers sit at zero outside their state, so every entry starts a fresh count.
    tick_timer #(.W(8), .TERM(RING_SEC - 1)) u_ring_timer (
        .clk   (CLK),
        .rst   (RST),
        .clear (state_q != RINGING),
        .tick  (Tick),
        .tc    (ring_tc)
    );

    tick_timer #(.W(10), .TERM(SNOOZE_SEC - 1)) u_snz_timer (
        .clk   (CLK),
        .rst   (RST),
        .clear (state_q != SNOOZE),
        .tick  (Tick),
        .tc    (snz_tc)
    );

    assign hr_t_clamped = clamp_bcd(set1, HR_TENS_MAX);
    assign hr_o_clamped = clamp_bcd(set0, BCD_ONES_MAX);

    always_comb begin
        al_mo_d    = al_mo_q;
        al_mt_d    = al_mt_q;
        al_ho_d    = al_ho_q;
        al_ht_d    = al_ht_q;
        state_d    = state_q;
        tone_cnt_d = '0;
        buzzer_d   = 1'b0;

        if (set_we) begin
            if (set_sel) begin
                if (({4'd0, hr_t_clamped} * 8'd10 + {4'd0, hr_o_clamped}) > HOUR_MAX) begin
                    al_ht_d = 4'd2;
                    al_ho_d = 4'd3;
                end else begin
                    al_ht_d = hr_t_clamped;
                    al_ho_d = hr_o_clamped;
                end
            end else begin
                al_mt_d = clamp_bcd(set1, MIN_TENS_MAX);
                al_mo_d = clamp_bcd(set0, BCD_ONES_MAX);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (match) state_d = RINGING;
            end
            RINGING: begin
                if (stop)         state_d = IDLE;
                else if (snooze)  state_d = SNOOZE;
                else if (ring_tc) state_d = IDLE;
            end
            SNOOZE: begin
                if (stop)        state_d = IDLE;
                else if (match)  state_d = RINGING;
                else if (snz_tc) state_d = RINGING;
            end
            default: state_d = IDLE;
        endcase

        if (!alarm_on) state_d = IDLE;

        // Tone advances only while staying in RINGING; any entry or exit zeroes it.
        if (state_d == RINGING && state_q == RINGING) begin
            if (tone_cnt_q == TW'(TONE_DIV - 1)) begin
                tone_cnt_d = '0;
                buzzer_d   = ~buzzer_q;
            end else begin
                tone_cnt_d = tone_cnt_q + 1'b1;
                buzzer_d   = buzzer_q;
            end
        end

        ringing_d  = (state_d == RINGING);
        snoozing_d = (state_d == SNOOZE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            al_mo_q    <= '0;
            al_mt_q    <= '0;
            al_ho_q    <= '0;
            al_ht_q    <= '0;
            tone_cnt_q <= '0;
            buzzer_q   <= 1'b0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            al_mo_q    <= al_mo_d;
            al_mt_q    <= al_mt_d;
            al_ho_q    <= al_ho_d;
            al_ht_q    <= al_ht_d;
            tone_cnt_q <= tone_cnt_d;
            buzzer_q   <= buzzer_d;
            ringing_q  <= ringing_d;
            snoozing_q <= snoozing_d;
        end
    end

    assign al_min_ones = al_mo_q;
    assign al_min_tens = al_mt_q;
    assign al_hr_ones  = al_ho_q;
    assign al_hr_tens  = al_ht_q;
    assign buzzer      = buzzer_q;
    assign ringing     = ringing_q;
    assign snoozing    = snoozing_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: register-write table plus ring/snooze/stop sequences.
module tb_alarm_ctrl;

    logic       CLK = 1'b0;
    logic       RST, Tick, alarm_on, set_we, set_sel, stop, snooze;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens;
    logic [3:0] set0, set1;
    logic [3:0] al_min_ones, al_min_tens, al_hr_ones, al_hr_tens;
    logic       buzzer, ringing, snoozing;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        sel;
        logic [3:0]  s1;
        logic [3:0]  s0;
        logic [15:0] exp_regs;
    } wvec_t;

    wvec_t wv[13];

    alarm_ctrl #(.RING_SEC(60), .SNOOZE_SEC(300), .TONE_DIV(4)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Tick        (Tick),
        .sec_ones    (sec_ones),
        .sec_tens    (sec_tens),
        .min_ones    (min_ones),
        .min_tens    (min_tens),
        .hr_ones     (hr_ones),
        .hr_tens     (hr_tens),
        .alarm_on    (alarm_on),
        .set_we      (set_we),
        .set_sel     (set_sel),
        .set0        (set0),
        .set1        (set1),
        .stop        (stop),
        .snooze      (snooze),
        .al_min_ones (al_min_ones),
        .al_min_tens (al_min_tens),
        .al_hr_ones  (al_hr_ones),
        .al_hr_tens  (al_hr_tens),
        .buzzer      (buzzer),
        .ringing     (ringing),
        .snoozing    (snoozing)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic logic [31:0] st();
        return {29'd0, ringing, snoozing, buzzer};
    endfunction

    function automatic logic [31:0] regs();
        return {16'd0, al_hr_tens, al_hr_ones, al_min_tens, al_min_ones};
    endfunction

    task automatic tick_pulse();
        Tick = 1'b1;
        cyc(1);
        Tick = 1'b0;
    endtask

    // Present 07:30:00 with Tick for one edge, then move the seconds on.
    task automatic trigger();
        hr_tens = 4'd0; hr_ones = 4'd7; min_tens = 4'd3; min_ones = 4'd0;
        sec_tens = 4'd0; sec_ones = 4'd0;
        Tick = 1'b1;
        cyc(1);
        Tick = 1'b0;
        sec_ones = 4'd1;
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1;
        cyc(1);
        snooze = 1'b0;
    endtask

    initial begin
        wv[0]  = '{1'b0, 4'd3,  4'd0,  16'h0030};
        wv[1]  = '{1'b1, 4'd0,  4'd7,  16'h0730};
        wv[2]  = '{1'b0, 4'd7,  4'd12, 16'h0759};
        wv[3]  = '{1'b1, 4'd3,  4'd8,  16'h2359};
        wv[4]  = '{1'b1, 4'd1,  4'd9,  16'h1959};
        wv[5]  = '{1'b1, 4'd2,  4'd4,  16'h2359};
        wv[6]  = '{1'b0, 4'd0,  4'd0,  16'h2300};
        wv[7]  = '{1'b1, 4'd15, 4'd15, 16'h2300};
        wv[8]  = '{1'b1, 4'd0,  4'd0,  16'h0000};
        wv[9]  = '{1'b0, 4'd6,  4'd10, 16'h0059};
        wv[10] = '{1'b1, 4'd2,  4'd3,  16'h2359};
        wv[11] = '{1'b0, 4'd3,  4'd0,  16'h2330};
        wv[12] = '{1'b1, 4'd0,  4'd7,  16'h0730};

        RST = 1'b1; Tick = 1'b0; alarm_on = 1'b1;
        set_we = 1'b0; set_sel = 1'b0; set0 = 4'd0; set1 = 4'd0;
        stop = 1'b0; snooze = 1'b0;
        hr_tens = 4'd1; hr_ones = 4'd2; min_tens = 4'd0; min_ones = 4'd0;
        sec_tens = 4'd0; sec_ones = 4'd1;
        cyc(2);
        chk("reset_regs", regs(), 32'h0000);
        chk("reset_status", st(), 32'd0);
        RST = 1'b0;

        for (int i = 0; i < 13; i++) begin
            set_we = 1'b1; set_sel = wv[i].sel; set1 = wv[i].s1; set0 = wv[i].s0;
            cyc(1);
            set_we = 1'b0;
            chk($sformatf("write_row%0d", i), regs(), {16'd0, wv[i].exp_regs});
        end

        // Right hh:mm but seconds not zero must not ring.
        hr_tens = 4'd0; hr_ones = 4'd7; min_tens = 4'd3; min_ones = 4'd0;
        sec_tens = 4'd0; sec_ones = 4'd5;
        tick_pulse();
        cyc(2);
        chk("no_ring_sec05", st(), 32'd0);

        alarm_on = 1'b0;
        trigger();
        chk("no_ring_disarmed", st(), 32'd0);
        alarm_on = 1'b1;
        cyc(1);

        trigger();
        chk("ring_entry", st(), 32'b100);
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            chk($sformatf("tone_k%0d", k), 32'(buzzer), 32'((k / 4) % 2));
        end

        repeat (59) begin
            tick_pulse();
            cyc(2);
        end
        chk("ring_after_59", 32'(ringing), 32'd1);
        tick_pulse();
        chk("auto_stop_60", st(), 32'd0);

        trigger();
        repeat (5) begin
            tick_pulse();
            cyc(1);
        end
        pulse_snooze();
        chk("snooze_entry", st(), 32'b010);
        snooze = 1'b1;
        cyc(3);
        snooze = 1'b0;
        chk("snooze_held", st(), 32'b010);
        repeat (299) begin
            tick_pulse();
            cyc(1);
        end
        chk("snooze_299", st(), 32'b010);
        tick_pulse();
        chk("snooze_expire", st(), 32'b100);
        cyc(4);
        chk("rering_tone", st(), 32'b101);
        repeat (59) begin
            tick_pulse();
            cyc(1);
        end
        chk("rering_after_59", 32'(ringing), 32'd1);
        tick_pulse();
        chk("rering_auto_stop", st(), 32'd0);

        trigger();
        stop = 1'b1; snooze = 1'b1;
        cyc(1);
        stop = 1'b0; snooze = 1'b0;
        chk("stop_beats_snooze", st(), 32'd0);

        trigger();
        pulse_snooze();
        chk("snooze_again", st(), 32'b010);
        trigger();
        chk("snooze_match_restart", st(), 32'b100);
        pulse_snooze();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("stop_in_snooze", st(), 32'd0);

        trigger();
        pulse_snooze();
        alarm_on = 1'b0;
        cyc(1);
        chk("disarm_in_snooze", st(), 32'd0);
        alarm_on = 1'b1;

        trigger();
        alarm_on = 1'b0;
        cyc(1);
        chk("disarm_in_ring", st(), 32'd0);
        alarm_on = 1'b1;

        trigger();
        cyc(5);
        chk("pre_reset_ring", st(), 32'b101);
        RST = 1'b1;
        set_we = 1'b1; set_sel = 1'b1; set1 = 4'd1; set0 = 4'd2;
        cyc(1);
        RST = 1'b0; set_we = 1'b0;
        chk("reset_mid_ring_status", st(), 32'd0);
        chk("reset_mid_ring_regs", regs(), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
